boot_sequencer: RTL

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/boot_pkg.sv | 17 +
 rtl/byte_packer.sv | 28 ++
 rtl/boot_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the serial boot loader: state encoding and checksum width.
package boot_pkg;
    localparam int CSUM_W = 8;
    typedef logic [CSUM_W-1:0] csum_t;

    localparam logic [2:0] RX_ADDR  = 3'd0;
    localparam logic [2:0] RX_COUNT = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] WRITE    = 3'd3;
    localparam logic [2:0] RX_CSUM  = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;
    localparam logic [2:0] ERROR    = 3'd6;

    function automatic logic is_rx_state(input logic [2:0] s);
        return (s == RX_ADDR) || (s == RX_COUNT) || (s == RX_DATA) || (s == RX_CSUM);
    endfunction
endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler; word_o is valid combinationally alongside the 4th byte.
// Zero latency (last_o/word_o qualify the current byte); no backpressure, caller gates byte_vld_i.
module byte_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  idx_o,
    output logic        last_o,
    output logic [31:0] word_o
);
    logic [23:0] shift_q;
    logic [1:0]  idx_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (byte_vld_i) begin
            shift_q <= {shift_q[15:0], byte_i};
            idx_q   <= idx_q + 2'd1;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = byte_vld_i && (idx_q == 2'd3);
    assign word_o = {shift_q, byte_i};
endmodule

// File: rtl/boot_sequencer.sv
// Serial boot loader: receives address, count, data words and XOR checksum, writes words to memory.
// One word write per 4 data bytes plus a 1-cycle WRITE state; serial_rden_out drops during WRITE/DONE/ERROR.
module boot_sequencer
    import boot_pkg::*;
#(
    parameter logic [31:0] MAX_WORDS      = 32'd65536,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  serial_in,
    input  logic        serial_valid_in,
    output logic        serial_rden_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic        mem_we_out,
    output logic        cpu_stall_out,
    output logic        load_done_out,
    output logic        error_out,
    output logic [31:0] words_loaded_out
);
    logic [2:0]  state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] count_q, count_d;
    logic [31:0] words_q, words_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] idle_q, idle_d;
    csum_t       csum_q, csum_d;

    logic        accept;
    logic        pack_vld;
    logic [1:0]  pack_idx;
    logic        pack_last;
    logic [31:0] pack_word;
    logic        idle_counting;
    logic        timeout;

    assign accept   = serial_rden_out && serial_valid_in;
    assign pack_vld = accept && (state_q != RX_CSUM);

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .byte_vld_i (pack_vld),
        .byte_i     (serial_in),
        .idx_o      (pack_idx),
        .last_o     (pack_last),
        .word_o     (pack_word)
    );

    // The host may wait forever before the first address byte, so the watchdog only arms once a packet starts.
    assign idle_counting = (state_q == RX_COUNT) || (state_q == RX_DATA) || (state_q == RX_CSUM) ||
                           ((state_q == RX_ADDR) && (pack_idx != 2'd0));
    assign timeout       = idle_counting && !accept && (idle_q >= TIMEOUT_CYCLES - 32'd1);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        words_d = words_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        csum_d  = csum_q;
        idle_d  = idle_q;

        if (accept) begin
            idle_d = '0;
        end else if (idle_counting) begin
            idle_d = idle_q + 32'd1;
        end

        if (pack_vld) begin
            csum_d = csum_q ^ serial_in;
        end

        case (state_q)
            RX_ADDR: begin
                if (pack_last) begin
                    base_d  = pack_word;
                    state_d = (pack_word[1:0] != 2'b00) ? ERROR : RX_COUNT;
                end
            end
            RX_COUNT: begin
                if (pack_last) begin
                    count_d = pack_word;
                    if (pack_word > MAX_WORDS) begin
                        state_d = ERROR;
                    end else if (pack_word == 32'd0) begin
                        state_d = RX_CSUM;
                    end else begin
                        state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (pack_last) begin
                    wdata_d = pack_word;
                    addr_d  = base_q + {words_q[29:0], 2'b00};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                words_d = words_q + 32'd1;
                state_d = ((words_q + 32'd1) == count_q) ? RX_CSUM : RX_DATA;
            end
            RX_CSUM: begin
                if (accept) begin
                    state_d = (serial_in == csum_q) ? DONE : ERROR;
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase

        if (timeout) begin
            state_d = ERROR;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RX_ADDR;
            base_q  <= '0;
            count_q <= '0;
            words_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            csum_q  <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            words_q <= words_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            csum_q  <= csum_d;
            idle_q  <= idle_d;
        end
    end

    assign serial_rden_out  = is_rx_state(state_q);
    assign mem_we_out       = (state_q == WRITE);
    assign mem_addr_out     = addr_q;
    assign mem_wdata_out    = wdata_q;
    assign cpu_stall_out    = (state_q != DONE);
    assign load_done_out    = (state_q == DONE);
    assign error_out        = (state_q == ERROR);
    assign words_loaded_out = words_q;
endmodule
